scanline_doubler: RTL and testbench
===================================

# scanline_doubler

Fetches Mode 13h framebuffer rows (320×200, 8-bit palette indices) over a request/acknowledge memory port. Replays each row as two physical 640-pixel lines, emitting every logical pixel for two consecutive clocks. It sits between video memory and the palette/DAC stage, driven by the VGA controller's `h_count`/`v_count`. It turns logical framebuffer contents into the physical pixel stream for the centred 640×400 window.

## Interface
- `H_OFFSET`, 80: first physical column of the logical window.
- `V_OFFSET`, 40: first physical line of the logical window.
- `LOGICAL_WIDTH`, 320: logical pixels per row.
- `LOGICAL_HEIGHT`, 200: logical rows.
- `BORDER_INDEX`, 8'h00: index driven outside the window.

Ports:
- `clk_25mhz`  in  1  pixel clock; sole clock.
- `reset`  in  1  synchronous, active-high.
- `h_count`  in  10  physical horizontal counter.
- `v_count`  in  10  physical vertical counter.
- `display_enable`  in  1  visible-area flag from the VGA controller.
- `mem_req`  out  1  read request; held until acknowledged.
- `mem_addr`  out  16  framebuffer byte address, row*320+col.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_data` is valid in the same cycle.
- `mem_data`  in  8  returned palette index.
- `pixel_index`  out  8  palette index for the current physical pixel.
- `pixel_valid`  out  1  `pixel_index` is from the logical window.
- `underrun`  out  1  sticky flag: a row fetch did not finish in time.

## Operation
- Two 320×8 line buffers (ping-pong), selected by logical row bit 0. Row r is written to bank r[0] and displayed from bank r[0].
- Fetch trigger: `h_count==0` and `v_count==V_OFFSET-2+2r` for r = 0..199. The fetch for row r therefore runs during display of row r-1, or during line 38 for r=0. The budget is 1600 clocks.
- Fetch FSM, two states:
  - IDLE: `mem_req`=0. On trigger, latch row=r, col=0, go to FETCH.
  - FETCH: `mem_req`=1, `mem_addr`=row*320+col (16-bit; max 63999).
    - On `mem_ack`, write `mem_data` to buf[row[0]][col].
    - If col==319, go to IDLE; else col+1.
    - `mem_addr` and `mem_req` are registered and update the cycle after `mem_ack`.
- Only one request is outstanding. `mem_ack` while in IDLE is ignored.
- Trigger while in FETCH:
  - Set `underrun`=1.
  - Abandon the current row.
  - Restart at the new row, col=0, remaining in FETCH with no idle cycle.
- Display path:
  - In window when `display_enable` is high, `H_OFFSET` ≤ `h_count` < `H_OFFSET`+640, and `V_OFFSET` ≤ `v_count` < `V_OFFSET`+400.
  - When in window: col=(h_count−H_OFFSET)>>1, row=(v_count−V_OFFSET)>>1, read buf[row[0]][col].
  - Outside window: drive `BORDER_INDEX`.
- Simultaneous buffer write and display read never target the same bank by construction. No bypass is required.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0, `pixel_index`=`BORDER_INDEX`, `pixel_valid`=0, `underrun`=0.
  - FSM in IDLE, col=0.
  - Buffer contents are not cleared.
- Reset mid-fetch: next cycle `mem_req`=0, FSM in IDLE. A pending ack is ignored.
- Display latency: exactly 1 clock. `pixel_index`/`pixel_valid` at cycle t+1 correspond to `h_count`/`v_count`/`display_enable` at cycle t.
  - Implies a synchronous-read buffer, registered output.
- Each logical pixel appears on 2 consecutive clocks. Each row appears on 2 consecutive physical lines.
- Zero-wait memory (ack in the cycle after req rises): a row completes in ≤ 640 clocks.
- `underrun` stays 1 until `reset`.

## Test plan
- Reset check:
  - Stimulus: assert `reset` 3 cycles with `h_count`=100, `v_count`=50, `display_enable`=1.
  - Required: `mem_req`=0, `pixel_valid`=0, `pixel_index`=0x00, `underrun`=0.
- Row 0 fetch:
  - Stimulus: memory model with data = addr[7:0] ^ 0x5A, 1-cycle ack. Drive `v_count`=38, `h_count`=0.
  - Required: 320 requests with addresses 0..319 in order; `mem_req` drops after the ack for address 319.
- Pixel doubling:
  - Stimulus: after the row 0 fetch, sweep line 40 then line 41.
  - Required:
    - `pixel_index` at h=80,81 (seen one cycle later) = 0x5A, h=82,83 = 0x5B.
    - Line 41 is identical to line 40.
    - `pixel_valid` falls one cycle after h=720.
- Last row and address width:
  - Stimulus: trigger at `v_count`=436 (r=199).
  - Required: addresses 63680..63999; lines 438/439 show that row from bank 1.
- Underrun:
  - Stimulus: ack delay of 6 clocks; run frames.
  - Required:
    - `underrun` sets at the trigger of row r+1 while row r is incomplete.
    - The fetch restarts at address (r+1)*320.
    - The flag holds until `reset`.
- Border and reset mid-fetch:
  - Stimulus: `v_count`=20 and `h_count`=40 with `display_enable`=1; then assert `reset` during FETCH at col=150.
  - Required:
    - Border case: `pixel_index`=0x00, `pixel_valid`=0.
    - Reset case: `mem_req`=0 on the next cycle; the next trigger restarts at col 0.

Source files
------------

// File: rtl/scanline_doubler.sv
// Mode 13h scanline doubler: fetches 320-pixel rows into ping-pong line buffers
// and replays every logical pixel and row twice into the centred 640x400 window.
module scanline_doubler #(
   parameter int         H_OFFSET       = 80,
   parameter int         V_OFFSET       = 40,
   parameter int         LOGICAL_WIDTH  = 320,
   parameter int         LOGICAL_HEIGHT = 200,
   parameter logic [7:0] BORDER_INDEX   = 8'h00
) (
   input  logic        clk_25mhz,
   input  logic        reset,
   input  logic [9:0]  h_count,
   input  logic [9:0]  v_count,
   input  logic        display_enable,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic [7:0]  pixel_index,
   output logic        pixel_valid,
   output logic        underrun
);

   localparam logic [9:0]  H_LO     = 10'(H_OFFSET);
   localparam logic [9:0]  H_HI     = 10'(H_OFFSET + 2 * LOGICAL_WIDTH);
   localparam logic [9:0]  V_LO     = 10'(V_OFFSET);
   localparam logic [9:0]  V_HI     = 10'(V_OFFSET + 2 * LOGICAL_HEIGHT);
   localparam logic [9:0]  TRIG_LO  = 10'(V_OFFSET - 2);
   localparam logic [8:0]  ROWS     = 9'(LOGICAL_HEIGHT);
   localparam logic [8:0]  COL_LAST = 9'(LOGICAL_WIDTH - 1);
   localparam logic [15:0] ROW_SPAN = 16'(LOGICAL_WIDTH);

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} fetch_state_t;

   fetch_state_t state, state_next;
   logic [7:0]   row, row_next;
   logic [8:0]   col, col_next;
   logic [15:0]  addr_next;
   logic         underrun_next;
   logic         wr_en;

   logic [7:0]   line_buf [2][LOGICAL_WIDTH];

   // Row r is fetched starting at h_count==0 of physical line V_OFFSET-2+2r,
   // i.e. while row r-1 is on screen.
   logic [9:0] trig_rel;
   logic       trigger;
   logic [7:0] trig_row;

   assign trig_rel = v_count - TRIG_LO;
   assign trigger  = (h_count == 10'd0) && (v_count >= TRIG_LO) &&
                     !trig_rel[0] && (trig_rel[9:1] < ROWS);
   assign trig_row = trig_rel[8:1];

   // Memory port: mem_req stays high with a stable mem_addr until a cycle with
   // mem_ack; mem_data is taken in that same cycle and the next address is
   // presented one clock later. One request outstanding at most.
   assign mem_req = (state == FETCH);

   always_comb begin
      state_next    = state;
      row_next      = row;
      col_next      = col;
      underrun_next = underrun;
      wr_en         = 1'b0;
      if (trigger) begin
         if (state == FETCH) underrun_next = 1'b1;
         state_next = FETCH;
         row_next   = trig_row;
         col_next   = 9'd0;
      end else if (state == FETCH && mem_ack) begin
         wr_en = 1'b1;
         if (col == COL_LAST) begin
            state_next = IDLE;
            col_next   = 9'd0;
         end else begin
            col_next = col + 9'd1;
         end
      end
      addr_next = 16'(row_next) * ROW_SPAN + 16'(col_next);
   end

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state    <= IDLE;
         row      <= 8'd0;
         col      <= 9'd0;
         mem_addr <= 16'd0;
         underrun <= 1'b0;
      end else begin
         state    <= state_next;
         row      <= row_next;
         col      <= col_next;
         underrun <= underrun_next;
         if (state_next == FETCH) mem_addr <= addr_next;
      end
   end

   // Writes go to the bank being filled; the display reads the other bank.
   always_ff @(posedge clk_25mhz) begin
      if (wr_en && !reset) line_buf[row[0]][col] <= mem_data;
   end

   logic       in_window;
   logic [8:0] disp_col;
   logic       disp_bank;

   assign in_window = display_enable &&
                      (h_count >= H_LO) && (h_count < H_HI) &&
                      (v_count >= V_LO) && (v_count < V_HI);
   assign disp_col  = 9'((h_count - H_LO) >> 1);
   assign disp_bank = 1'((v_count - V_LO) >> 1);

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         pixel_index <= BORDER_INDEX;
         pixel_valid <= 1'b0;
      end else if (in_window) begin
         pixel_index <= line_buf[disp_bank][disp_col];
         pixel_valid <= 1'b1;
      end else begin
         pixel_index <= BORDER_INDEX;
         pixel_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scanline_doubler.sv
// Bench for scanline_doubler: memory model with adjustable ack delay, table
// vectors, line sweeps and random pixels against a framebuffer-level model.
module tb_scanline_doubler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  h_count = 10'd0;
   logic [9:0]  v_count = 10'd0;
   logic        display_enable = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_data = 8'h00;
   logic [7:0]  pixel_index;
   logic        pixel_valid;
   logic        underrun;

   scanline_doubler dut (
      .clk_25mhz      (clk),
      .reset          (reset),
      .h_count        (h_count),
      .v_count        (v_count),
      .display_enable (display_enable),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_data       (mem_data),
      .pixel_index    (pixel_index),
      .pixel_valid    (pixel_valid),
      .underrun       (underrun)
   );

   always #20 clk = ~clk;

   int   checks = 0;
   int   passes = 0;
   int   ack_delay = 0;
   int   wait_cnt = 0;
   int   req_log[$];
   int   bank_row[2] = '{-1, -1};
   bit   chk_pix = 1'b0;
   logic [8:0] pend = 9'd0;

   function automatic logic [7:0] fb(input int a);
      return 8'(a) ^ 8'h5A;
   endfunction

   // Framebuffer-level view: the pixel shown is the logical pixel of whatever
   // row currently occupies the bank selected by the displayed row's parity.
   function automatic logic [8:0] ref_out(input int h, input int v, input logic de);
      int r, c, src;
      if (de && h >= 80 && h < 720 && v >= 40 && v < 440) begin
         r   = (v - 40) / 2;
         c   = (h - 80) / 2;
         src = bank_row[r % 2];
         return {1'b1, fb(src * 320 + c)};
      end
      return {1'b0, 8'h00};
   endfunction

   // Memory: answers each request after ack_delay idle clocks, logs addresses.
   always begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack  = 1'b1;
            mem_data = fb(int'(mem_addr));
            req_log.push_back(int'(mem_addr));
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic cycle(input int h, input int v, input logic de);
      @(negedge clk);
      if (chk_pix) begin
         check("pix_index", int'(pixel_index), int'(pend[7:0]));
         check("pix_valid", int'(pixel_valid), int'(pend[8]));
      end
      h_count        = 10'(h);
      v_count        = 10'(v);
      display_enable = de;
      pend           = ref_out(h, v, de);
   endtask

   task automatic run_until_idle(input int v, input int budget, output int used);
      used = 0;
      do begin
         cycle(1 + (used % 799), v, 1'b0);
         used++;
      end while (mem_req && used < budget);
      check("fetch_done", int'(mem_req), 0);
   endtask

   task automatic check_log(input string name, input int base, input int n);
      check({name, "_count"}, req_log.size(), n);
      for (int i = 0; i < n && i < req_log.size(); i++) check(name, req_log[i], base + i);
   endtask

   task automatic sweep(input int v);
      for (int h = 1; h < 800; h++) begin
         cycle(h, v, 1'b1);
         if (h == 720) check("valid_at_719", int'(pixel_valid), 1);
         if (h == 721) check("valid_fall_720", int'(pixel_valid), 0);
      end
   endtask

   typedef struct {
      int         h;
      int         v;
      logic       de;
      logic [7:0] idx;
      logic       valid;
   } vec_t;

   vec_t vecs[12];
   int   used;
   int   n;

   initial begin
      vecs[0]  = '{80,  40, 1'b1, 8'h5A, 1'b1};
      vecs[1]  = '{81,  40, 1'b1, 8'h5A, 1'b1};
      vecs[2]  = '{82,  40, 1'b1, 8'h5B, 1'b1};
      vecs[3]  = '{83,  40, 1'b1, 8'h5B, 1'b1};
      vecs[4]  = '{81,  41, 1'b1, 8'h5A, 1'b1};
      vecs[5]  = '{83,  41, 1'b1, 8'h5B, 1'b1};
      vecs[6]  = '{100, 40, 1'b1, 8'h50, 1'b1};
      vecs[7]  = '{719, 41, 1'b1, 8'h65, 1'b1};
      vecs[8]  = '{720, 40, 1'b1, 8'h00, 1'b0};
      vecs[9]  = '{79,  40, 1'b1, 8'h00, 1'b0};
      vecs[10] = '{40,  20, 1'b1, 8'h00, 1'b0};
      vecs[11] = '{100, 40, 1'b0, 8'h00, 1'b0};

      // Reset with the counters inside the window.
      reset = 1'b1; h_count = 10'd100; v_count = 10'd50; display_enable = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_mem_req", int'(mem_req), 0);
      check("reset_pixel_valid", int'(pixel_valid), 0);
      check("reset_pixel_index", int'(pixel_index), 0);
      check("reset_underrun", int'(underrun), 0);
      check("reset_mem_addr", int'(mem_addr), 0);
      reset = 1'b0;

      // Row 0 fetch with zero-wait memory.
      req_log.delete();
      cycle(0, 38, 1'b0);
      run_until_idle(38, 1000, used);
      check_log("row0_addr", 0, 320);
      check("row0_within_640", int'(used <= 640), 1);
      bank_row[0] = 0;

      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].h, vecs[i].v, vecs[i].de);
         cycle(1, 600, 1'b0);
         check($sformatf("vec%0d_index", i), int'(pixel_index), int'(vecs[i].idx));
         check($sformatf("vec%0d_valid", i), int'(pixel_valid), int'(vecs[i].valid));
      end

      // Lines 40 and 41 both show row 0, every pixel doubled.
      chk_pix = 1'b1;
      sweep(40);
      sweep(41);
      cycle(1, 600, 1'b0);
      chk_pix = 1'b0;

      // Last row lands in bank 1 with the top addresses.
      req_log.delete();
      cycle(0, 436, 1'b0);
      run_until_idle(436, 1000, used);
      check_log("row199_addr", 63680, 320);
      bank_row[1] = 199;
      chk_pix = 1'b1;
      sweep(438);
      sweep(439);
      cycle(1, 600, 1'b0);

      repeat (1500) cycle($urandom_range(1, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)));
      cycle(1, 600, 1'b0);
      chk_pix = 1'b0;

      // Reset in the middle of row 2 (col 150), then a clean refetch.
      ack_delay = 0;
      cycle(0, 42, 1'b0);
      n = 0;
      while (mem_addr != 16'd790 && n < 400) begin
         cycle(1 + n, 42, 1'b0);
         n++;
      end
      check("reach_col150", int'(mem_addr), 790);
      reset = 1'b1;
      cycle(5, 42, 1'b0);
      check("req_low_after_reset", int'(mem_req), 0);
      check("addr_after_reset", int'(mem_addr), 0);
      reset = 1'b0;
      repeat (3) begin
         cycle(6, 42, 1'b0);
         check("req_stays_low", int'(mem_req), 0);
      end
      req_log.delete();
      cycle(0, 42, 1'b0);
      run_until_idle(42, 1000, used);
      check_log("row2_addr", 640, 320);
      bank_row[0] = 2;
      check("no_underrun_yet", int'(underrun), 0);

      // Slow memory: row 5 cannot finish before row 6 is triggered.
      ack_delay = 6;
      cycle(0, 48, 1'b0);
      for (int h = 1; h < 800; h++) cycle(h, 48, 1'b0);
      for (int h = 0; h < 800; h++) cycle(h, 49, 1'b0);
      check("underrun_before", int'(underrun), 0);
      check("row5_incomplete", int'(mem_req), 1);
      req_log.delete();
      cycle(0, 50, 1'b0);
      cycle(1, 50, 1'b0);
      check("underrun_set", int'(underrun), 1);
      check("restart_addr", int'(mem_addr), 1920);
      check("restart_req", int'(mem_req), 1);
      for (int h = 2; h < 60; h++) cycle(h, 50, 1'b0);
      check("restart_first_ack", (req_log.size() > 0) ? req_log[0] : -1, 1920);
      ack_delay = 0;
      n = 0;
      while (mem_req && n < 1000) begin
         cycle(2 + (n % 700), 51, 1'b0);
         n++;
      end
      check("row6_done", int'(mem_req), 0);
      check_log("row6_addr", 1920, 320);
      check("underrun_holds", int'(underrun), 1);
      reset = 1'b1;
      cycle(2, 51, 1'b0);
      cycle(3, 51, 1'b0);
      reset = 1'b0;
      cycle(4, 51, 1'b0);
      check("underrun_cleared", int'(underrun), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
